// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB next-PC predictor with 2-bit saturating counters
// and branch / branch-miss statistics.
module branch_predictor #(
  parameter int WORD_SIZE        = 16,
  parameter int INDEX_BITS       = 4,
  parameter int BRANCH_PREDICTOR = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pred_next_pc,
  output logic                 pred_taken,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_mispredict,
  output logic [WORD_SIZE-1:0] num_branch,
  output logic [WORD_SIZE-1:0] num_branch_miss
);
  localparam int N  = 1 << INDEX_BITS;
  localparam int TW = WORD_SIZE - INDEX_BITS;
  logic [N-1:0]                valid_q, valid_d;
  logic [N-1:0][TW-1:0]        tag_q, tag_d;
  logic [N-1:0][WORD_SIZE-1:0] target_q, target_d;
  logic [N-1:0][1:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]        nb_q, nb_d, nbm_q, nbm_d;
  logic [INDEX_BITS-1:0]       idx, uidx;
  logic                        hit, uhit;
  assign idx  = pc[INDEX_BITS-1:0];
  assign uidx = update_pc[INDEX_BITS-1:0];
  assign hit  = valid_q[idx] && tag_q[idx] == pc[WORD_SIZE-1:INDEX_BITS];
  assign uhit = valid_q[uidx] && tag_q[uidx] == update_pc[WORD_SIZE-1:INDEX_BITS];
  assign pred_taken = (BRANCH_PREDICTOR == 1) ? hit :
                      (BRANCH_PREDICTOR == 2) ? hit && cnt_q[idx][1] : 1'b0;
  assign pred_next_pc    = pred_taken ? target_q[idx] : pc + WORD_SIZE'(1);
  assign num_branch      = nb_q;
  assign num_branch_miss = nbm_q;
  assign nb_d  = update_valid ? nb_q + WORD_SIZE'(1) : nb_q;
  assign nbm_d = (update_valid && update_mispredict) ? nbm_q + WORD_SIZE'(1) : nbm_q;
  // Lookups read the _q arrays only, so a same-cycle update to the index is not bypassed.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (update_valid && BRANCH_PREDICTOR != 0) begin
      if (uhit) begin
        cnt_d[uidx] = update_taken ? ((cnt_q[uidx] == 2'b11) ? 2'b11 : cnt_q[uidx] + 2'd1)
                                   : ((cnt_q[uidx] == 2'b00) ? 2'b00 : cnt_q[uidx] - 2'd1);
        if (update_taken) target_d[uidx] = update_target;
      end else if (update_taken) begin
        valid_d[uidx]  = 1'b1;
        tag_d[uidx]    = update_pc[WORD_SIZE-1:INDEX_BITS];
        target_d[uidx] = update_target;
        cnt_d[uidx]    = 2'b10;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      cnt_q    <= {N{2'b01}};
      nb_q     <= '0;
      nbm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      nb_q     <= nb_d;
      nbm_q    <= nbm_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: three predictor instances (modes 0/1/2) on shared stimulus,
// checked every cycle against a table-based model plus directed literal expectations.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc, update_pc, update_target;
  logic        update_valid, update_taken, update_mispredict;
  logic [15:0] pn[3], nb[3], nbm[3];
  logic        pt[3];
  int          checks = 0, failures = 0;
  bit          started = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .BRANCH_PREDICTOR(g)) u (
      .clk(clk), .reset_n(reset_n), .pc(pc),
      .pred_next_pc(pn[g]), .pred_taken(pt[g]),
      .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
      .update_target(update_target), .update_mispredict(update_mispredict),
      .num_branch(nb[g]), .num_branch_miss(nbm[g])
    );
  end

  // Behavioural model: one table of entries per mode, indexed by pc mod 16.
  bit          m_valid[3][16];
  int          m_tag[3][16];
  int          m_target[3][16];
  int          m_cnt[3][16];
  int          m_nb = 0, m_nbm = 0;

  task automatic model_reset();
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 16; i++) begin
        m_valid[m][i] = 0; m_tag[m][i] = 0; m_target[m][i] = 0; m_cnt[m][i] = 1;
      end
    m_nb = 0; m_nbm = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else if (update_valid) begin
      int i, t;
      i = update_pc % 16;
      t = update_pc / 16;
      m_nb = (m_nb + 1) % 65536;
      if (update_mispredict) m_nbm = (m_nbm + 1) % 65536;
      for (int m = 1; m < 3; m++) begin
        if (m_valid[m][i] && m_tag[m][i] == t) begin
          m_cnt[m][i] = update_taken ? ((m_cnt[m][i] < 3) ? m_cnt[m][i] + 1 : 3)
                                     : ((m_cnt[m][i] > 0) ? m_cnt[m][i] - 1 : 0);
          if (update_taken) m_target[m][i] = update_target;
        end else if (update_taken) begin
          m_valid[m][i] = 1; m_tag[m][i] = t; m_target[m][i] = update_target; m_cnt[m][i] = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 3; m++) begin
        int i;
        bit hit, tk;
        i   = pc % 16;
        hit = m_valid[m][i] && m_tag[m][i] == pc / 16;
        tk  = (m == 0) ? 0 : (m == 1) ? hit : (hit && m_cnt[m][i] >= 2);
        chk($sformatf("model_taken_m%0d", m), {15'd0, pt[m]}, {15'd0, tk});
        chk($sformatf("model_next_m%0d", m), pn[m], tk ? 16'(m_target[m][i]) : 16'((pc + 1) % 65536));
        chk($sformatf("model_nb_m%0d", m), nb[m], 16'(m_nb));
        chk($sformatf("model_nbm_m%0d", m), nbm[m], 16'(m_nbm));
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] up, input logic t, input logic [15:0] tg,
                     input logic mis, input logic [15:0] p);
    @(posedge clk); #1;
    update_valid = v; update_pc = up; update_taken = t; update_target = tg;
    update_mispredict = mis; pc = p;
    @(negedge clk);
  endtask

  task automatic look(input string name, input int m, input logic [15:0] exp_pc, input logic exp_t);
    chk({name, "_pc"}, pn[m], exp_pc);
    chk({name, "_taken"}, {15'd0, pt[m]}, {15'd0, exp_t});
  endtask

  function automatic logic [15:0] rpc();
    logic [15:0] tags[4];
    tags[0] = 16'h0020; tags[1] = 16'h0010; tags[2] = 16'h1230; tags[3] = 16'hFFF0;
    return tags[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
  endfunction

  initial begin
    reset_n = 1'b0; pc = 16'h0010;
    update_valid = 0; update_pc = 0; update_taken = 0; update_target = 0; update_mispredict = 0;
    @(posedge clk); #1; started = 1;
    @(negedge clk);
    look("reset", 2, 16'h0011, 1'b0);
    chk("reset_nb", nb[2], 16'h0000);
    chk("reset_nbm", nbm[2], 16'h0000);
    @(posedge clk); #1; reset_n = 1'b1;
    cyc(1, 16'h0023, 1, 16'h0040, 0, 16'h0023); look("alloc_same_cycle", 2, 16'h0024, 1'b0);
    cyc(1, 16'h0023, 0, 16'h0000, 0, 16'h0023); look("alloc_hit", 2, 16'h0040, 1'b1);
    cyc(1, 16'h0023, 0, 16'h0000, 0, 16'h0023); look("cnt01", 2, 16'h0024, 1'b0);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'h0023); look("cnt00", 2, 16'h0024, 1'b0);
    repeat (4) cyc(1, 16'h0023, 1, 16'h0040, 0, 16'h0023);
    cyc(1, 16'h0023, 0, 16'h0000, 0, 16'h0023); look("sat11", 2, 16'h0040, 1'b1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'h0023); look("sat_then_nt", 2, 16'h0040, 1'b1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'h0013); look("tag_miss", 2, 16'h0014, 1'b0);
    cyc(1, 16'h0023, 1, 16'h0055, 0, 16'h0023); look("nobypass_old", 2, 16'h0040, 1'b1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'h0023); look("nobypass_new", 2, 16'h0055, 1'b1);
    look("mode0_hit", 0, 16'h0024, 1'b0);
    look("mode1_hit", 1, 16'h0055, 1'b1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF); look("wrap", 2, 16'h0000, 1'b0);
    cyc(1, 16'h0037, 1, 16'h0099, 0, 16'h0037);
    repeat (3) cyc(1, 16'h0037, 0, 16'h0000, 0, 16'h0037);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'h0037);
    look("mode1_sticky", 1, 16'h0099, 1'b1);
    look("mode2_cnt00", 2, 16'h0038, 1'b0);
    look("mode0_never", 0, 16'h0038, 1'b0);
    @(posedge clk); #1; reset_n = 1'b0; update_valid = 0; @(negedge clk);
    chk("rst1_nb", nb[2], 16'h0000);
    look("rst1_miss", 1, 16'h0038, 1'b0);
    @(posedge clk); #1; reset_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 16'h0100 + 16'(i), 0, 16'h0000, (i == 1 || i == 3), 16'h0000);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    chk("stat_nb", nb[2], 16'd5);
    chk("stat_nbm", nbm[2], 16'd2);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 16'h0023);
    chk("stat_nbm_ignore", nbm[1], 16'd2);
    cyc(1, 16'h0023, 1, 16'h0077, 1, 16'h0023);
    #2 reset_n = 1'b0; @(negedge clk);
    chk("rst2_nb", nb[1], 16'h0000);
    chk("rst2_nbm", nbm[1], 16'h0000);
    look("rst2_miss", 1, 16'h0024, 1'b0);
    @(posedge clk); #1; reset_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      reset_n = ($urandom_range(0, 299) != 0);
      update_valid = $urandom_range(0, 1); update_pc = rpc();
      update_taken = $urandom_range(0, 2) != 0; update_target = 16'($urandom);
      update_mispredict = $urandom_range(0, 1); pc = rpc();
    end
    @(posedge clk); #1; reset_n = 1'b1; update_valid = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
